// File: rtl/lu_pkg.sv
// -----------------------------------------------------------------------------
// lu_pkg
//   Shared definitions for the LU factorization control path and datapath.
//   Contents:
//     LU_N_DEF, LU_DIV_LAT_DEF : default matrix dimension / divider drain
//     LU_CNT_W                 : width of the divider-drain counter (1..31)
//     lu_state_e               : step scheduler state encoding
//     lu_clog2()               : ceil(log2(v)), never below 1
// -----------------------------------------------------------------------------
package lu_pkg;

  localparam int LU_N_DEF       = 4;
  localparam int LU_DIV_LAT_DEF = 3;
  localparam int LU_CNT_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIV   = 3'd1,
    ST_DWAIT = 3'd2,
    ST_UPD   = 3'd3,
    ST_FIN   = 3'd4
  } lu_state_e;

  // Index widths must stay at least one bit even for degenerate sizes.
  function automatic int lu_clog2(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < v) r = b + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/lu_lat_counter.sv
// -----------------------------------------------------------------------------
// lu_lat_counter
//   Loadable, enable-gated down-counter with terminal-count flag.
//   Load has priority over enable; the count saturates at zero.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset (count -> 0)
//     i_load       : load i_load_val this cycle
//     i_load_val   : value to load
//     i_en         : decrement when not loading
//     o_tc         : count is zero
// -----------------------------------------------------------------------------
module lu_lat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/lu_step_scheduler.sv
// -----------------------------------------------------------------------------
// lu_step_scheduler
//   Sequences the in-place LU factorization of an N x N matrix:
//   for each pivot k, issue divides l[i][k] for i = k+1..N-1, let the
//   divider drain for DIV_LAT cycles, then issue trailing-submatrix updates
//   a[i][j] for i,j in k+1..N-1 (row-major).  A zero pivot aborts with a
//   sticky error flag.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     start               : begin factorization (sampled in IDLE only)
//     stall               : datapath hold; freezes DIV/DWAIT/UPD progress
//     pivot_zero          : a[k][k] == 0, checked on first divide of each k
//     k_idx, i_idx, j_idx : current pivot / row / column
//     div_en, upd_en      : issue strobes (combinationally gated by stall)
//     busy                : not IDLE
//     done                : one-cycle completion pulse (FIN state)
//     error               : sticky singular-pivot flag, cleared by start
// -----------------------------------------------------------------------------
module lu_step_scheduler
  import lu_pkg::*;
#(
  parameter  int N       = LU_N_DEF,
  parameter  int DIV_LAT = LU_DIV_LAT_DEF,
  localparam int IDX_W   = lu_clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             pivot_zero,
  output logic [IDX_W-1:0] k_idx,
  output logic [IDX_W-1:0] i_idx,
  output logic [IDX_W-1:0] j_idx,
  output logic             div_en,
  output logic             upd_en,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [IDX_W-1:0]    L_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]    L_PEN  = IDX_W'(N - 2);
  // Counter holds DIV_LAT-1 so that DWAIT spans exactly DIV_LAT live cycles
  // (the cycle that sees terminal count is the last wait cycle).
  localparam logic [LU_CNT_W-1:0] L_LAT  = LU_CNT_W'(DIV_LAT - 1);

  lu_state_e        r_state, w_state_nx;
  logic [IDX_W-1:0] r_k, r_i, r_j;
  logic [IDX_W-1:0] w_k_nx, w_i_nx, w_j_nx;
  logic             r_err, w_err_nx;
  logic [IDX_W-1:0] w_k_p1, w_k_p2;
  logic             w_first;
  logic             w_cnt_load, w_cnt_en, w_cnt_tc;

  assign w_k_p1  = r_k + IDX_W'(1);
  // Only used when k < N-2, so k+2 <= N-1 always fits.
  assign w_k_p2  = r_k + IDX_W'(2);
  // First divide slot of the current pivot; the pivot check lives here.
  assign w_first = (r_i == w_k_p1);

  lu_lat_counter #(.W(LU_CNT_W)) u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (L_LAT),
    .i_en       (w_cnt_en),
    .o_tc       (w_cnt_tc)
  );

  // State and index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_i     <= w_i_nx;
      r_j     <= w_j_nx;
      r_err   <= w_err_nx;
    end
  end

  // Next state / next indices.  Stall only holds the working states; IDLE
  // and FIN keep moving so the done pulse is never stretched.
  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_i_nx     = r_i;
    w_j_nx     = r_j;
    w_err_nx   = r_err;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_DIV;
          w_k_nx     = '0;
          w_i_nx     = IDX_W'(1);
          w_j_nx     = '0;
          w_err_nx   = 1'b0;
        end
      end
      ST_DIV: begin
        if (!stall) begin
          if (w_first && pivot_zero) begin
            w_err_nx   = 1'b1;
            w_state_nx = ST_FIN;
          end else if (r_i == L_LAST) begin
            w_state_nx = ST_DWAIT;
            w_cnt_load = 1'b1;
          end else begin
            w_i_nx = r_i + IDX_W'(1);
          end
        end
      end
      ST_DWAIT: begin
        if (!stall) begin
          if (w_cnt_tc) begin
            w_state_nx = ST_UPD;
            w_i_nx     = w_k_p1;
            w_j_nx     = w_k_p1;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      ST_UPD: begin
        if (!stall) begin
          if (r_j == L_LAST) begin
            if (r_i == L_LAST) begin
              if (r_k == L_PEN) begin
                w_state_nx = ST_FIN;
              end else begin
                // Next pivot: j tracks k while dividing.
                w_state_nx = ST_DIV;
                w_k_nx     = w_k_p1;
                w_i_nx     = w_k_p2;
                w_j_nx     = w_k_p1;
              end
            end else begin
              w_i_nx = r_i + IDX_W'(1);
              w_j_nx = w_k_p1;
            end
          end else begin
            w_j_nx = r_j + IDX_W'(1);
          end
        end
      end
      ST_FIN:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Outputs: strobes are gated by stall/pivot combinationally, the rest is
  // decoded from registered state.
  always_comb begin
    div_en = (r_state == ST_DIV) && !stall && !(w_first && pivot_zero);
    upd_en = (r_state == ST_UPD) && !stall;
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_FIN);
    error  = r_err;
    k_idx  = r_k;
    i_idx  = r_i;
    j_idx  = r_j;
  end

endmodule

// File: tb/tb_lu_step_scheduler.sv
module tb_lu_step_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic pz = 1'b0;
  logic sel = 1'b0;   // 0: N=4 instance, 1: N=2 instance

  always #5 clk = ~clk;

  logic [1:0] k4, i4, j4;
  logic       d4, u4, b4, f4, e4;
  logic [0:0] k2, i2, j2;
  logic       d2, u2, b2, f2, e2;

  lu_step_scheduler #(.N(4), .DIV_LAT(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .stall(stall), .pivot_zero(pz),
    .k_idx(k4), .i_idx(i4), .j_idx(j4), .div_en(d4), .upd_en(u4),
    .busy(b4), .done(f4), .error(e4)
  );

  lu_step_scheduler #(.N(2), .DIV_LAT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .stall(stall), .pivot_zero(pz),
    .k_idx(k2), .i_idx(i2), .j_idx(j2), .div_en(d2), .upd_en(u2),
    .busy(b2), .done(f2), .error(e2)
  );

  logic [3:0] s_k, s_i, s_j;
  logic       s_div, s_upd, s_busy, s_done, s_err;

  always_comb begin
    if (sel) begin
      s_k = {3'b0, k2}; s_i = {3'b0, i2}; s_j = {3'b0, j2};
      s_div = d2; s_upd = u2; s_busy = b2; s_done = f2; s_err = e2;
    end else begin
      s_k = {2'b0, k4}; s_i = {2'b0, i4}; s_j = {2'b0, j4};
      s_div = d4; s_upd = u4; s_busy = b4; s_done = f4; s_err = e4;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", tag, act, exp);
    end
  endtask

  // Reference issue order: {upd, k, i, j}, j = k on divides.
  logic [12:0] exp_q[$];

  function automatic void build(input int n);
    exp_q.delete();
    for (int k = 0; k <= n - 2; k++) begin
      for (int i = k + 1; i < n; i++)
        exp_q.push_back({1'b0, 4'(k), 4'(i), 4'(k)});
      for (int i = k + 1; i < n; i++)
        for (int j = k + 1; j < n; j++)
          exp_q.push_back({1'b1, 4'(k), 4'(i), 4'(j)});
    end
  endfunction

  int          q_idx, n_div, n_upd, done_cyc, err_c1;
  logic [11:0] snap;

  // Called just after a negedge with the DUT idle. Cycle 1 is the cycle after
  // start is sampled. Ends at the negedge of cycle maxc.
  task automatic run(input int maxc, input int sf, input int sl, input int pzc, input bit hold);
    q_idx = 0; n_div = 0; n_upd = 0; done_cyc = -1; err_c1 = -1;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= maxc; c++) begin
      #1;
      start = hold;
      stall = (c >= sf) && (c < sf + sl);
      pz    = (c == pzc);
      @(negedge clk);
      if (c == 1) err_c1 = int'(s_err);
      if (s_div || s_upd) begin
        if (q_idx < exp_q.size())
          chk("issue", int'({s_upd, s_k, s_i, s_j}), int'(exp_q[q_idx]));
        else
          chk("extra_issue", q_idx, exp_q.size() - 1);
        q_idx++;
        if (s_div) n_div++; else n_upd++;
      end
      if (stall) begin
        chk("stall_en", int'(s_div | s_upd), 0);
        if (c == sf) snap = {s_k, s_i, s_j};
        else chk("stall_idx", int'({s_k, s_i, s_j}), int'(snap));
      end
      if (s_done && done_cyc < 0) done_cyc = c;
      if (c < maxc) @(posedge clk);
    end
    stall = 1'b0;
    pz    = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(s_busy), 0);
    chk({tag, "_done"}, int'(s_done), 0);
    chk({tag, "_err"},  int'(s_err),  0);
    chk({tag, "_en"},   int'(s_div | s_upd), 0);
    chk({tag, "_idx"},  int'({s_k, s_i, s_j}), 0);
  endtask

  initial begin
    @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal N=4 run
    sel = 1'b0;
    build(4);
    run(32, 0, 0, 0, 1'b0);
    chk("nom_done", done_cyc, 30);
    chk("nom_ndiv", n_div, 6);
    chk("nom_nupd", n_upd, 14);
    chk("nom_nissue", q_idx, 20);

    // Stall 5 cycles inside k=1 update phase (cycles 22..26)
    run(40, 22, 5, 0, 1'b0);
    chk("stl_done", done_cyc, 35);
    chk("stl_ndiv", n_div, 6);
    chk("stl_nupd", n_upd, 14);

    // Zero pivot at first k=1 divide (cycle 16)
    run(20, 0, 0, 16, 1'b0);
    chk("pz_done", done_cyc, 17);
    chk("pz_ndiv", n_div, 3);
    chk("pz_nupd", n_upd, 9);
    chk("pz_err_sticky", int'(s_err), 1);
    chk("pz_idle", int'(s_busy), 0);

    // Next start clears error; reset mid-DWAIT at k=0 (cycle 5)
    run(5, 0, 0, 0, 1'b0);
    chk("err_clr", err_c1, 0);
    chk("dwait_busy", int'(s_busy), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(32, 0, 0, 0, 1'b0);
    chk("post_rst_done", done_cyc, 30);
    chk("post_rst_ndiv", n_div, 6);
    chk("post_rst_nupd", n_upd, 14);

    // start held through the run plus two cycles
    run(31, 0, 0, 0, 1'b1);
    chk("hold_done", done_cyc, 30);
    chk("hold_nissue", q_idx, 20);
    chk("hold_idle", int'(s_busy), 0);
    @(posedge clk);
    #1;
    @(negedge clk);   // cycle 32: second run's first divide
    chk("hold_rerun_div", int'(s_div), 1);
    chk("hold_rerun_idx", int'({s_k, s_i}), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cyc = -1;
    for (int c = 33; c <= 80; c++) begin
      @(negedge clk);
      if (s_done && done_cyc < 0) done_cyc = c;
    end
    chk("hold_rerun_done", done_cyc, 61);

    // N=2, DIV_LAT=1
    sel = 1'b1;
    build(2);
    run(8, 0, 0, 0, 1'b0);
    chk("n2_done", done_cyc, 4);
    chk("n2_ndiv", n_div, 1);
    chk("n2_nupd", n_upd, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
